axi_len_partition: RTL and testbench

- Generalised AXI burst-length partitioner for the DMA read and write paths.
- Accepts one byte-granular transfer descriptor (start address, byte length) and issues a sequence of INCR address-channel commands.
- Each burst is capped at MAX_BL beats and never crosses a 4 KB boundary.
- Supports unaligned start/end bytes, two split modes, abort, and completion signalling.
- One instance drives either an AW or an AR channel.

---
 rtl/axi_len_partition_if.sv | 31 +++
 rtl/axi_len_partition.sv | 191 +++++++++++++++++++
 tb/tb_axi_len_partition.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_len_partition_if.sv
// AXI address-channel command bundle (AW or AR) produced by axi_len_partition.
//   master : drives axid/axaddr/axlen/axsize/axburst/axvalid and the
//            ax_first/ax_last sidebands; samples axready.
//   slave  : the consumer side of the same signals.
interface axi_len_partition_if #(
  parameter int AXI_AW     = 32,
  parameter int AXI_IW     = 8,
  parameter int AXI_LW     = 8,
  parameter int AXI_SW     = 3,
  parameter int AXI_BURSTW = 2
);
  logic [AXI_IW-1:0]     axid;
  logic [AXI_AW-1:0]     axaddr;
  logic [AXI_LW-1:0]     axlen;
  logic [AXI_SW-1:0]     axsize;
  logic [AXI_BURSTW-1:0] axburst;
  logic                  axvalid;
  logic                  axready;
  logic                  ax_first;
  logic                  ax_last;

  modport master (
    output axid, axaddr, axlen, axsize, axburst, axvalid, ax_first, ax_last,
    input  axready
  );

  modport slave (
    input  axid, axaddr, axlen, axsize, axburst, axvalid, ax_first, ax_last,
    output axready
  );
endinterface

// File: rtl/axi_len_partition.sv
// Burst-length partitioner: turns one byte-granular descriptor (start
// address, byte length) into a sequence of INCR address-channel commands.
// Each burst is at most MAX_BL beats and never crosses a 4 KB page.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_valid/cfg_ready descriptor handshake (ready only while idle)
//   cfg_sa, cfg_len     start byte address, length in bytes
//   cfg_abort           stop after the burst currently being offered
//   ax                  address-channel command bundle (master side)
//   busy                a descriptor is being issued
//   done, done_abort    one-cycle completion pulse, and "ended by abort"
module axi_len_partition #(
  parameter int AXI_DW      = 128,
  parameter int AXI_AW      = 32,
  parameter int AXI_IW      = 8,
  parameter int AXI_LW      = 8,
  parameter int AXI_SW      = 3,
  parameter int AXI_BURSTW  = 2,
  parameter int AXI_ID      = 1,
  parameter int MAX_BL      = 16,
  parameter int ALIGN_BURST = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [31:0]         cfg_sa,
  input  logic [31:0]         cfg_len,
  input  logic                cfg_abort,
  axi_len_partition_if.master ax,
  output logic                busy,
  output logic                done,
  output logic                done_abort
);

  localparam int AXI_BYTES  = AXI_DW / 8;
  localparam int L          = $clog2(AXI_BYTES);
  localparam int BW         = AXI_AW - L;        // beat-address width
  localparam int RW         = 33 - L;            // remaining-beats width
  localparam int PAGE_BEATS = 4096 / AXI_BYTES;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t            state_q, state_d;

  // Position of the burst currently on the bus (its start beat and the
  // beats still owed from that point on).
  logic [BW-1:0]     beat_addr_q;
  logic [RW-1:0]     rem_q;
  logic              abort_pend_q;

  logic [AXI_AW-1:0] axaddr_q;
  logic [AXI_LW-1:0] axlen_q;
  logic              ax_first_q;
  logic              ax_last_q;
  logic              axvalid_q;
  logic              done_q;
  logic              done_abort_q;

  // Beats the next burst may carry from beat address ba with r beats left.
  function automatic logic [RW-1:0] burst_beats(input logic [BW-1:0] ba,
                                                input logic [RW-1:0] r);
    logic [RW-1:0] bl_room;
    logic [RW-1:0] pg_room;
    logic [RW-1:0] bnd;
    bl_room = RW'(MAX_BL) - RW'(ba % BW'(MAX_BL));
    pg_room = RW'(PAGE_BEATS) - RW'(ba % BW'(PAGE_BEATS));
    // MAX_BL-aligned bursts can never straddle a page, so the page limit
    // only matters when bursts run full-length from an arbitrary start.
    if (ALIGN_BURST != 0) bnd = bl_room;
    else                  bnd = (pg_room < RW'(MAX_BL)) ? pg_room : RW'(MAX_BL);
    return (r < bnd) ? r : bnd;
  endfunction

  // Descriptor decode: beat span covering [sa, sa+len-1] at 33-bit precision
  logic              accept;
  logic              start;
  logic [BW-1:0]     ba_init;
  logic [RW-1:0]     rem_init;
  logic [RW-1:0]     beats_init;

  always_comb begin
    accept     = cfg_valid & cfg_ready;
    start      = accept & (cfg_len != 32'd0);
    ba_init    = cfg_sa[AXI_AW-1:L];
    rem_init   = RW'((({1'b0, cfg_sa} + {1'b0, cfg_len} - 33'd1) >> L)
                     - ({1'b0, cfg_sa} >> L) + 33'd1);
    beats_init = burst_beats(ba_init, rem_init);
  end

  // Handshake evaluation and precomputation of the following burst
  logic              hs;
  logic              nat_last;
  logic              fin;
  logic [RW-1:0]     beats_cur;
  logic [BW-1:0]     ba_nxt;
  logic [RW-1:0]     rem_nxt;
  logic [RW-1:0]     beats_nxt;

  always_comb begin
    hs        = axvalid_q & ax.axready;
    beats_cur = RW'(axlen_q) + RW'(1);
    nat_last  = (beats_cur == rem_q);
    // A pending abort ends the descriptor at whichever handshake comes next.
    fin       = hs & (nat_last | abort_pend_q);
    ba_nxt    = beat_addr_q + BW'(beats_cur);
    rem_nxt   = rem_q - beats_cur;
    beats_nxt = burst_beats(ba_nxt, rem_nxt);
  end

  // Control FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_valid && (cfg_len != 32'd0)) state_d = ISSUE;
      ISSUE:   if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and command registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      axvalid_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
      done_abort_q <= 1'b0;
      ax_first_q   <= 1'b0;
      ax_last_q    <= 1'b0;
      axaddr_q     <= '0;
      axlen_q      <= '0;
    end else begin
      state_q      <= state_d;
      // A zero-length descriptor completes without issuing anything.
      done_q       <= fin | (accept & (cfg_len == 32'd0));
      // An abort that lands on the natural last burst is a normal finish.
      done_abort_q <= fin & abort_pend_q & ~nat_last;
      if (start) begin
        axvalid_q    <= 1'b1;
        abort_pend_q <= 1'b0;
        axaddr_q     <= cfg_sa[AXI_AW-1:0];
        axlen_q      <= AXI_LW'(beats_init - RW'(1));
        ax_first_q   <= 1'b1;
        ax_last_q    <= (beats_init == rem_init);
      end else if (fin) begin
        axvalid_q    <= 1'b0;
        abort_pend_q <= 1'b0;
        ax_first_q   <= 1'b0;
        ax_last_q    <= 1'b0;
      end else if (hs) begin
        axaddr_q     <= AXI_AW'(ba_nxt) << L;
        axlen_q      <= AXI_LW'(beats_nxt - RW'(1));
        ax_first_q   <= 1'b0;
        // An abort arriving on this handshake truncates after the next burst.
        ax_last_q    <= (beats_nxt == rem_nxt) | cfg_abort;
        abort_pend_q <= cfg_abort;
      end else if ((state_q == ISSUE) && cfg_abort) begin
        abort_pend_q <= 1'b1;
        ax_last_q    <= 1'b1;
      end
    end
  end

  // Position tracking; only meaningful while issuing, so left unreset
  always_ff @(posedge clk) begin
    if (start) begin
      beat_addr_q <= ba_init;
      rem_q       <= rem_init;
    end else if (hs) begin
      beat_addr_q <= ba_nxt;
      rem_q       <= rem_nxt;
    end
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign done_abort = done_abort_q;

  assign ax.axid    = AXI_IW'(AXI_ID);
  assign ax.axaddr  = axaddr_q;
  assign ax.axlen   = axlen_q;
  assign ax.axsize  = AXI_SW'(L);
  assign ax.axburst = AXI_BURSTW'(1);
  assign ax.axvalid = axvalid_q;
  assign ax.ax_first = ax_first_q;
  assign ax.ax_last  = ax_last_q;

endmodule

// File: tb/tb_axi_len_partition.sv
// Self-checking bench: two partitioners (ALIGN_BURST=1 and 0) share the
// descriptor inputs; each has its own scoreboard of expected bursts and
// completion flags, popped by a per-instance monitor.
module tb_axi_len_partition;

  localparam int BYTES  = 16;
  localparam int MAX_BL = 16;
  localparam int PAGE   = 4096 / BYTES;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        first;
    logic        last;
  } burst_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] cfg_sa = '0;
  logic [31:0] cfg_len = '0;
  logic        rdy_mode = 1'b0;
  logic        rdy_force = 1'b0;
  logic        rnd_r [2];

  logic        cfg_ready_w [2];
  logic        busy_w [2];
  logic        done_w [2];
  logic        dab_w [2];
  logic [31:0] addr_w [2];
  logic [7:0]  len_w [2];
  logic [7:0]  id_w [2];
  logic [2:0]  size_w [2];
  logic [1:0]  bt_w [2];
  logic        av_w [2];
  logic        ar_w [2];
  logic        af_w [2];
  logic        al_w [2];

  int checks = 0;
  int errors = 0;

  burst_t exp_q [2][$];
  bit     dab_q [2][$];

  always #5 clk = ~clk;

  axi_len_partition_if ifa ();
  axi_len_partition_if ifu ();

  axi_len_partition #(.ALIGN_BURST(1)) u_al (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_w[0]),
    .cfg_sa(cfg_sa), .cfg_len(cfg_len), .cfg_abort(cfg_abort), .ax(ifa),
    .busy(busy_w[0]), .done(done_w[0]), .done_abort(dab_w[0]));

  axi_len_partition #(.ALIGN_BURST(0)) u_un (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_w[1]),
    .cfg_sa(cfg_sa), .cfg_len(cfg_len), .cfg_abort(cfg_abort), .ax(ifu),
    .busy(busy_w[1]), .done(done_w[1]), .done_abort(dab_w[1]));

  assign ar_w[0] = rdy_mode ? rdy_force : rnd_r[0];
  assign ar_w[1] = rdy_mode ? rdy_force : rnd_r[1];
  assign ifa.axready = ar_w[0];
  assign ifu.axready = ar_w[1];
  assign addr_w[0] = ifa.axaddr;   assign addr_w[1] = ifu.axaddr;
  assign len_w[0]  = ifa.axlen;    assign len_w[1]  = ifu.axlen;
  assign id_w[0]   = ifa.axid;     assign id_w[1]   = ifu.axid;
  assign size_w[0] = ifa.axsize;   assign size_w[1] = ifu.axsize;
  assign bt_w[0]   = ifa.axburst;  assign bt_w[1]   = ifu.axburst;
  assign av_w[0]   = ifa.axvalid;  assign av_w[1]   = ifu.axvalid;
  assign af_w[0]   = ifa.ax_first; assign af_w[1]   = ifu.ax_first;
  assign al_w[0]   = ifa.ax_last;  assign al_w[1]   = ifu.ax_last;

  initial begin
    rnd_r[0] = 1'b0;
    rnd_r[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      rnd_r[0] = ($urandom_range(0, 3) != 0);
      rnd_r[1] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish within 50000 cycles");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic        pv, pr, pf, pend;
    logic [31:0] pa;
    logic [7:0]  pl;
    initial begin pv = 0; pr = 0; pf = 0; pend = 0; pa = 0; pl = 0; end
    always @(negedge clk) begin : mon
      burst_t e;
      bit     d;
      logic   hs;
      if (reset) begin
        pv = 0; pr = 0; pend = 0;
      end else begin
        if (pv && !pr) begin
          checks++;
          if (!(av_w[g] && addr_w[g] == pa && len_w[g] == pl && af_w[g] == pf)) begin
            errors++;
            $display("FAIL stall%0d: got v=%b addr=%h len=%0d first=%b, expected v=1 addr=%h len=%0d first=%b",
                     g, av_w[g], addr_w[g], len_w[g], af_w[g], pa, pl, pf);
          end
        end
        if (done_w[g]) begin
          checks++;
          if (!pend) begin
            errors++;
            $display("FAIL done_timing%0d: got done=1, expected done=0", g);
          end
          checks++;
          if (dab_q[g].size() == 0) begin
            errors++;
            $display("FAIL done_unexpected%0d: got done=1 abort=%b, expected no completion", g, dab_w[g]);
          end else begin
            d = dab_q[g].pop_front();
            if (dab_w[g] !== d) begin
              errors++;
              $display("FAIL done_abort%0d: got %b expected %b", g, dab_w[g], d);
            end
          end
        end else if (pend) begin
          checks++;
          errors++;
          $display("FAIL done_missing%0d: got done=0 expected done=1", g);
        end
        hs = av_w[g] && ar_w[g];
        if (hs) begin
          checks++;
          if (exp_q[g].size() == 0) begin
            errors++;
            $display("FAIL burst_unexpected%0d: got addr=%h len=%0d, expected no burst", g, addr_w[g], len_w[g]);
          end else begin
            e = exp_q[g].pop_front();
            if (addr_w[g] !== e.addr || len_w[g] !== e.len || af_w[g] !== e.first ||
                al_w[g] !== e.last || id_w[g] !== 8'd1 || size_w[g] !== 3'd4 || bt_w[g] !== 2'd1) begin
              errors++;
              $display("FAIL burst%0d: got addr=%h len=%0d first=%b last=%b id=%0d size=%0d burst=%0d, expected addr=%h len=%0d first=%b last=%b id=1 size=4 burst=1",
                       g, addr_w[g], len_w[g], af_w[g], al_w[g], id_w[g], size_w[g], bt_w[g],
                       e.addr, e.len, e.first, e.last);
            end
          end
        end
        pend = (hs && al_w[g]) || (cfg_valid && cfg_ready_w[g] && cfg_len == 32'd0);
        pv = av_w[g]; pr = ar_w[g]; pa = addr_w[g]; pl = len_w[g]; pf = af_w[g];
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [7:0] l, input logic f, input logic la);
    burst_t b;
    b.addr = a; b.len = l; b.first = f; b.last = la;
    exp_q[0].push_back(b);
    exp_q[1].push_back(b);
  endtask

  task automatic push_done(input bit ab);
    dab_q[0].push_back(ab);
    dab_q[1].push_back(ab);
  endtask

  // Reference partitioning in byte/beat arithmetic on unbounded integers.
  task automatic model(input int inst, input logic [31:0] sa, input logic [31:0] len, input bit align);
    longint unsigned b, b0, last_b, lim, pg_end, nb;
    burst_t bb;
    if (len == 0) return;
    b0     = longint'(sa) / BYTES;
    last_b = (longint'(sa) + longint'(len) - 1) / BYTES;
    b      = b0;
    while (b <= last_b) begin
      pg_end = (b / PAGE + 1) * PAGE;
      if (align) lim = (b / MAX_BL + 1) * MAX_BL;
      else       lim = (b + MAX_BL < pg_end) ? b + MAX_BL : pg_end;
      nb = (lim < last_b + 1) ? lim : last_b + 1;
      bb.addr  = (b == b0) ? sa : 32'(b * BYTES);
      bb.len   = 8'(nb - b - 1);
      bb.first = (b == b0);
      bb.last  = (nb == last_b + 1);
      exp_q[inst].push_back(bb);
      b = nb;
    end
  endtask

  task automatic issue(input logic [31:0] sa, input logic [31:0] len);
    int n = 0;
    while (!(cfg_ready_w[0] && cfg_ready_w[1]) && n < 4000) begin tick(); n++; end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL cfg_ready_timeout: got ready=%b/%b expected 1/1", cfg_ready_w[0], cfg_ready_w[1]);
    end
    cfg_sa = sa; cfg_len = len; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run_model_job(input logic [31:0] sa, input logic [31:0] len);
    model(0, sa, len, 1'b1);
    model(1, sa, len, 1'b0);
    push_done(1'b0);
    issue(sa, len);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + dab_q[0].size() + dab_q[1].size()) != 0 && n < 4000) begin
      tick(); n++;
    end
    if (n >= 4000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d outstanding items, expected 0",
               nm, exp_q[0].size() + exp_q[1].size() + dab_q[0].size() + dab_q[1].size());
      exp_q[0].delete(); exp_q[1].delete(); dab_q[0].delete(); dab_q[1].delete();
    end
  endtask

  initial begin
    logic [31:0] sa, len;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(cfg_ready_w[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i),  32'(busy_w[i]), 32'd0);
      chk($sformatf("rst_valid%0d", i), 32'(av_w[i]), 32'd0);
      chk($sformatf("rst_done%0d", i),  32'({done_w[i], dab_w[i]}), 32'd0);
      chk($sformatf("rst_side%0d", i),  32'({af_w[i], al_w[i]}), 32'd0);
      chk($sformatf("rst_addr%0d", i),  addr_w[i], 32'd0);
      chk($sformatf("rst_len%0d", i),   32'(len_w[i]), 32'd0);
    end

    // Aligned 1 KB job
    push(32'h000, 8'd15, 1'b1, 1'b0);
    push(32'h100, 8'd15, 1'b0, 1'b0);
    push(32'h200, 8'd15, 1'b0, 1'b0);
    push(32'h300, 8'd15, 1'b0, 1'b1);
    push_done(1'b0);
    issue(32'h0, 32'h400);
    chk("latency_valid0", 32'(av_w[0]), 32'd1);
    chk("busy0", 32'(busy_w[0]), 32'd1);
    wait_done("aligned");

    // Unaligned start crossing 4 KB
    push(32'hF38,  8'd12, 1'b1, 1'b0);
    push(32'h1000, 8'd3,  1'b0, 1'b1);
    push_done(1'b0);
    issue(32'hF38, 32'h100);
    wait_done("unaligned");

    // Page split
    push(32'hFC0,  8'd3,  1'b1, 1'b0);
    push(32'h1000, 8'd15, 1'b0, 1'b0);
    push(32'h1100, 8'd11, 1'b0, 1'b1);
    push_done(1'b0);
    issue(32'hFC0, 32'h200);
    wait_done("split");

    // Zero length
    push_done(1'b0);
    issue(32'h123, 32'h0);
    chk("zero_valid0", 32'(av_w[0]), 32'd0);
    chk("zero_valid1", 32'(av_w[1]), 32'd0);
    wait_done("zero");

    // Backpressure on burst 2 with abort during the stall
    rdy_mode = 1'b1; rdy_force = 1'b0;
    push(32'h000, 8'd15, 1'b1, 1'b0);
    push(32'h100, 8'd15, 1'b0, 1'b1);
    push_done(1'b1);
    issue(32'h0, 32'h400);
    rdy_force = 1'b1; tick(); rdy_force = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cfg_abort = (i == 2);
      tick();
    end
    cfg_abort = 1'b0;
    rdy_force = 1'b1; tick(); rdy_force = 1'b0;
    tick(); tick();
    chk("abort_novalid0", 32'(av_w[0]), 32'd0);
    chk("abort_novalid1", 32'(av_w[1]), 32'd0);
    wait_done("abort");

    // Abort pending when the natural last burst handshakes
    push(32'h000, 8'd15, 1'b1, 1'b1);
    push_done(1'b0);
    issue(32'h0, 32'h100);
    cfg_abort = 1'b1; tick();
    rdy_force = 1'b1; tick();
    rdy_force = 1'b0; cfg_abort = 1'b0;
    wait_done("abort_last");
    rdy_mode = 1'b0;

    // Abort while idle has no effect
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    run_model_job(32'h40, 32'h200);
    wait_done("idle_abort");

    // Reset after the first burst
    rdy_mode = 1'b1; rdy_force = 1'b0;
    push(32'h000, 8'd15, 1'b1, 1'b0);
    issue(32'h0, 32'h400);
    rdy_force = 1'b1; tick(); rdy_force = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q[0].delete(); exp_q[1].delete();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_rst_valid%0d", i), 32'(av_w[i]), 32'd0);
      chk($sformatf("mid_rst_busy%0d", i),  32'(busy_w[i]), 32'd0);
      chk($sformatf("mid_rst_ready%0d", i), 32'(cfg_ready_w[i]), 32'd1);
    end
    tick();
    chk("mid_rst_nodone", 32'({done_w[0], done_w[1]}), 32'd0);
    rdy_mode = 1'b0;
    run_model_job(32'h2F0, 32'h333);
    wait_done("post_reset");

    // Randomized descriptors, back to back
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0:       sa = $urandom();
        1:       sa = ($urandom_range(1, 31) << 12) - $urandom_range(0, 300);
        2:       sa = 32'hFFFFF000 + $urandom_range(0, 4095);
        default: sa = $urandom_range(0, 8191);
      endcase
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 2304);
      run_model_job(sa, len);
    end
    wait_done("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
